// File: rtl/hs_npu_exec_ctrl.sv
// hs_npu_exec_ctrl: layer sequencer for an NxN systolic array (load phases, compute, save).
// Define HS_NPU_WEIGHT_REUSE_EN to let a layer skip weight loading when weights are still resident.
module hs_npu_exec_ctrl #(
   parameter int unsigned N         = 8,
   parameter int unsigned LAT_EXTRA = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] cfg_num_inputs,
   input  logic        cfg_use_sums,
   input  logic        cfg_reuse_weights,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic        res_ready,
   output logic        res_valid,
   output logic [2:0]  state,
   output logic [15:0] beat_idx,
   output logic        compute_en,
   output logic        busy,
   output logic        done,
   output logic        cfg_err
);

   typedef enum logic [2:0] {
      IDLE             = 3'd0,
      LOADING_WEIGHTS  = 3'd1,
      LOADING_INPUTS   = 3'd2,
      LOADING_BIAS     = 3'd3,
      LOADING_SUMS     = 3'd4,
      READY_TO_COMPUTE = 3'd5,
      COMPUTING        = 3'd6,
      SAVING           = 3'd7
   } loading_state_t;

   localparam logic [16:0] W_LAST = 17'(N - 1);
   localparam logic [16:0] C_ADD  = 17'(2 * N - 2 + LAT_EXTRA);

   loading_state_t st, st_nxt;
   logic [16:0]    cnt, cnt_nxt;
   logic [15:0]    num_q;
   logic           sums_q;
   logic           latch;
   logic           done_q, done_nxt;
   logic           err_q, err_nxt;
   logic           beat;
   logic [16:0]    num_last;
   logic [16:0]    comp_last;

   // 17-bit terminal counts keep cfg_num_inputs = 65535 from wrapping
   assign num_last  = {1'b0, num_q} - 17'd1;
   assign comp_last = {1'b0, num_q} + C_ADD;

   assign ld_ready   = (st == LOADING_WEIGHTS) || (st == LOADING_INPUTS) ||
                       (st == LOADING_BIAS)    || (st == LOADING_SUMS);
   assign beat       = ld_valid && ld_ready;
   assign res_valid  = (st == SAVING);
   assign compute_en = (st == COMPUTING);
   assign busy       = (st != IDLE);
   assign state      = st;
   assign beat_idx   = cnt[15:0];
   assign done       = done_q;
   assign cfg_err    = err_q;

`ifdef HS_NPU_WEIGHT_REUSE_EN
   logic wl_q, wl_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         wl_q <= 1'b0;
      end else begin
         wl_q <= wl_nxt;
      end
   end
`else
   logic unused_reuse;
   assign unused_reuse = cfg_reuse_weights;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         st     <= IDLE;
         cnt    <= '0;
         num_q  <= '0;
         sums_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         st     <= st_nxt;
         cnt    <= cnt_nxt;
         done_q <= done_nxt;
         err_q  <= err_nxt;
         if (latch) begin
            num_q  <= cfg_num_inputs;
            sums_q <= cfg_use_sums;
         end
      end
   end

   always_comb begin
      st_nxt   = st;
      cnt_nxt  = cnt;
      done_nxt = 1'b0;
      err_nxt  = 1'b0;
      latch    = 1'b0;
`ifdef HS_NPU_WEIGHT_REUSE_EN
      wl_nxt   = wl_q;
`endif
      case (st)
         IDLE: begin
            if (start) begin
               if (cfg_num_inputs == '0) begin
                  err_nxt = 1'b1;
               end else begin
                  latch   = 1'b1;
                  cnt_nxt = '0;
                  st_nxt  = LOADING_WEIGHTS;
`ifdef HS_NPU_WEIGHT_REUSE_EN
                  if (cfg_reuse_weights && wl_q) begin
                     st_nxt = LOADING_INPUTS;
                  end
`endif
               end
            end
         end
         LOADING_WEIGHTS: begin
            if (beat) begin
               if (cnt == W_LAST) begin
                  st_nxt  = LOADING_INPUTS;
                  cnt_nxt = '0;
`ifdef HS_NPU_WEIGHT_REUSE_EN
                  wl_nxt  = 1'b1;
`endif
               end else begin
                  cnt_nxt = cnt + 17'd1;
               end
            end
         end
         LOADING_INPUTS: begin
            if (beat) begin
               if (cnt == num_last) begin
                  st_nxt  = LOADING_BIAS;
                  cnt_nxt = '0;
               end else begin
                  cnt_nxt = cnt + 17'd1;
               end
            end
         end
         LOADING_BIAS: begin
            if (beat) begin
               st_nxt  = sums_q ? LOADING_SUMS : READY_TO_COMPUTE;
               cnt_nxt = '0;
            end
         end
         LOADING_SUMS: begin
            if (beat) begin
               if (cnt == num_last) begin
                  st_nxt  = READY_TO_COMPUTE;
                  cnt_nxt = '0;
               end else begin
                  cnt_nxt = cnt + 17'd1;
               end
            end
         end
         READY_TO_COMPUTE: begin
            st_nxt  = COMPUTING;
            cnt_nxt = '0;
         end
         COMPUTING: begin
            if (cnt == comp_last) begin
               st_nxt  = SAVING;
               cnt_nxt = '0;
            end else begin
               cnt_nxt = cnt + 17'd1;
            end
         end
         SAVING: begin
            if (res_ready) begin
               if (cnt == num_last) begin
                  st_nxt   = IDLE;
                  cnt_nxt  = '0;
                  done_nxt = 1'b1;
               end else begin
                  cnt_nxt = cnt + 17'd1;
               end
            end
         end
         default: begin
            st_nxt  = IDLE;
            cnt_nxt = '0;
         end
      endcase

      // abort overrides everything above, including a completing save beat
      if (abort && (st != IDLE)) begin
         st_nxt   = IDLE;
         cnt_nxt  = '0;
         done_nxt = 1'b0;
`ifdef HS_NPU_WEIGHT_REUSE_EN
         wl_nxt   = 1'b0;
`endif
      end
   end

endmodule
